// File: rtl/regfile_dump_pkg.sv
// Shared debug package: dump FSM state encoding and index constants.
// Imported by the regfile dump interface and the regfile_dump module.
package riscv_dbg_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [5:0] CSUM_INDEX = 6'h20;

  typedef logic [2:0] dump_state_t;

  localparam dump_state_t S_IDLE = 3'd0;
  localparam dump_state_t S_READ = 3'd1;
  localparam dump_state_t S_SEND = 3'd2;
  localparam dump_state_t S_CSUM = 3'd3;
  localparam dump_state_t S_FIN  = 3'd4;

endpackage

// File: rtl/regfile_dump_if.sv
// Beat stream from the register dumper to a debug sink.
// master: drives out_valid/out_index/out_data/out_last, samples out_ready.
interface regfile_dump_if
  import riscv_dbg_pkg::*;
#(
  parameter int DATA_W = 32
);

  logic                 out_valid;
  logic                 out_ready;
  logic [REG_IDX_W:0]   out_index;
  logic [DATA_W-1:0]    out_data;
  logic                 out_last;

  modport master (
    output out_valid,
    output out_index,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_index,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/regfile_dump.sv
// Debug reader: on start, walks FIRST_REG..LAST_REG through a spare
// register-file read port and streams {index, value} beats to a sink.
// Ports: clk, reset (sync, active-high), start, busy, done, rf_addr,
// rf_data, dout (regfile_dump_if.master).
// Optional: REGFILE_DUMP_CHECKSUM_EN appends an XOR checksum beat.
module regfile_dump
  import riscv_dbg_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [REG_IDX_W-1:0] rf_addr,
  input  logic [DATA_W-1:0]    rf_data,
  regfile_dump_if.master       dout
);

  localparam logic [REG_IDX_W-1:0] W_FIRST =
    REG_IDX_W'(FIRST_REG);
  localparam logic [REG_IDX_W-1:0] W_LAST =
    REG_IDX_W'(LAST_REG);

  dump_state_t          r_state;
  logic [REG_IDX_W-1:0] r_idx;
  logic [REG_IDX_W:0]   r_index;
  logic [DATA_W-1:0]    r_data;
  logic                 r_last;
  logic                 w_hs;
  logic                 w_at_last;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]    r_csum;
  logic                 w_csum_beat;
  assign w_csum_beat = (r_index == CSUM_INDEX);
`endif

  assign w_hs      = (r_state == S_SEND) && dout.out_ready;
  assign w_at_last = (r_idx == W_LAST);

  // Port is parked at 0 outside the read cycle.
  assign rf_addr = (r_state == S_READ) ? r_idx : '0;

  assign busy = (r_state == S_READ) ||
                (r_state == S_SEND) ||
                (r_state == S_CSUM);
  assign done = (r_state == S_FIN);

  assign dout.out_valid = (r_state == S_SEND);
  assign dout.out_index = r_index;
  assign dout.out_data  = r_data;
  assign dout.out_last  = r_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= W_FIRST;
      r_index <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx   <= W_FIRST;
            r_state <= S_READ;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            r_csum  <= '0;
`endif
          end
        end
        S_READ: begin
          r_index <= {1'b0, r_idx};
          r_data  <= rf_data;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          // Checksum beat is the last one.
          r_last  <= 1'b0;
          r_csum  <= r_csum ^ rf_data;
`else
          r_last  <= w_at_last;
`endif
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_hs) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            if (w_csum_beat)
              r_state <= S_FIN;
            else if (w_at_last)
              r_state <= S_CSUM;
`else
            if (w_at_last)
              r_state <= S_FIN;
`endif
            else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_READ;
            end
          end
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        S_CSUM: begin
          r_index <= CSUM_INDEX;
          r_data  <= r_csum;
          r_last  <= 1'b1;
          r_state <= S_SEND;
        end
`endif
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized bench for regfile_dump against a beat-list model.
// Covers full dumps, backpressure, single-reg, reset, start-while-busy.
module tb_regfile_dump;
  import riscv_dbg_pkg::*;

  localparam int DW = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int DONE_CYC = CSUM ? 67 : 65;

  typedef logic [38:0] beat_t;
  typedef beat_t bq_t[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rf [32];

  logic          busy, done, busy1, done1;
  logic [4:0]    rf_addr, rf_addr1;
  logic [DW-1:0] rf_data, rf_data1;

  regfile_dump_if #(.DATA_W(DW)) bus ();
  regfile_dump_if #(.DATA_W(DW)) bus1 ();

  assign rf_data  = (rf_addr == 5'd0) ? '0 : rf[rf_addr];
  assign rf_data1 = (rf_addr1 == 5'd0) ? '0 : rf[rf_addr1];

  regfile_dump #(
    .FIRST_REG(0), .LAST_REG(31), .DATA_W(DW)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .dout(bus)
  );

  regfile_dump #(
    .FIRST_REG(5), .LAST_REG(5), .DATA_W(DW)
  ) u_one (
    .clk(clk), .reset(reset), .start(start1),
    .busy(busy1), .done(done1),
    .rf_addr(rf_addr1), .rf_data(rf_data1),
    .dout(bus1)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference: one beat per register in range, x0 reads 0,
  // optional trailing XOR beat carries the last flag.
  function automatic bq_t model(int first, int last);
    bq_t e;
    logic [31:0] x = '0;
    logic [31:0] v;
    for (int i = first; i <= last; i++) begin
      v = (i == 0) ? 32'd0 : rf[i];
      x = x ^ v;
      e.push_back({(!CSUM && i == last), 6'(i), v});
    end
    if (CSUM) e.push_back({1'b1, 6'h20, x});
    return e;
  endfunction

  task automatic cmp_q(string tag, bq_t got, bq_t exp);
    int n;
    chk({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++)
      chk({tag, "_beat"}, 64'(got[i]), 64'(exp[i]));
  endtask

  int rdy_mode = 0;
  initial begin
    bus.out_ready  = 1'b1;
    bus1.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = (rdy_mode == 0) ||
                      ($urandom_range(0, 2) == 0);
    end
  end

  bq_t   q0, q1;
  int    done0 = 0;
  int    done1c = 0;
  bit    hold0 = 1'b0;
  beat_t held0;

  always @(negedge clk) begin
    beat_t b;
    if (done) done0++;
    if (done1) done1c++;
    if (bus.out_valid) begin
      b = {bus.out_last, bus.out_index, bus.out_data};
      if (hold0) chk("hold_stable", 64'(b), 64'(held0));
      if (bus.out_ready) q0.push_back(b);
      hold0 = !bus.out_ready;
      held0 = b;
    end else begin
      hold0 = 1'b0;
    end
    if (bus1.out_valid && bus1.out_ready)
      q1.push_back({bus1.out_last, bus1.out_index,
                    bus1.out_data});
  end

  // Full dump on u_dut; pulse_at>0 re-pulses start mid-dump.
  task automatic run_dump(string tag, int pulse_at);
    bq_t exp;
    int  cyc;
    int  first_v;
    exp = model(0, 31);
    q0.delete();
    done0 = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    first_v = -1;
    chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
    while (!done && cyc < 1000) begin
      if (bus.out_valid && first_v < 0) first_v = cyc;
      start = (pulse_at > 0 && cyc == pulse_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    chk({tag, "_first_valid"}, 64'(first_v), 64'd2);
    if (rdy_mode == 0)
      chk({tag, "_done_cycle"}, 64'(cyc), 64'(DONE_CYC));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_busy_fall"}, 64'(busy), 64'd0);
    repeat (6) @(negedge clk);
    chk({tag, "_done_count"}, 64'(done0), 64'd1);
    chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
    cmp_q(tag, q0, exp);
  endtask

  initial begin
    int cyc;
    bq_t exp1;
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_addr", 64'(rf_addr), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_last", 64'(bus.out_last), 64'd0);
    chk("rst_index", 64'(bus.out_index), 64'd0);

    rdy_mode = 0;
    run_dump("seq", 0);

    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rdy_mode = 1;
    run_dump("bp", 0);
    rdy_mode = 0;

    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    run_dump("busy_start", 20);

    rf[5] = 32'hDEADBEEF;
    exp1 = model(5, 5);
    q1.delete();
    done1c = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0;
    while (!done1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("one_done_seen", 64'(done1), 64'd1);
    repeat (3) @(negedge clk);
    chk("one_done_count", 64'(done1c), 64'd1);
    cmp_q("one", q1, exp1);

    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    q0.delete();
    done0 = 0;
    rdy_mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (q0.size() < 10 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid_reached", 64'(q0.size() >= 10), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid_no_done", 64'(done0), 64'd0);
    rdy_mode = 0;
    run_dump("restart", 0);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = 32'hF0F0_0000;
    rf[2] = 32'h0F0F_0000;
    run_dump("csum", 0);
    if (q0.size() == 33) begin
      chk("csum_beat", 64'(q0[32]),
          64'({1'b1, 6'h20, 32'hFFFF_0000}));
      chk("csum_prev_last", 64'(q0[31][38]), 64'd0);
    end else begin
      chk("csum_size", 64'(q0.size()), 64'd33);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
